// File: rtl/counter_cmd_ctrl.sv
// rtl/counter_cmd_ctrl.sv - command sequencer driving an 8-bit loadable up/down counter
// Optional CNT_CTRL_SAT_EN: UP/DOWN runs stop at the counter bounds instead of wrapping.
module counter_cmd_ctrl #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_arg,
    output logic          ld_cnt_,
    output logic          updn_cnt,
    output logic          count_enb,
    output logic [DW-1:0] data_in,
    output logic          busy,
    output logic          done,
    output logic          sat,
    output logic [DW-1:0] shadow_cnt
);
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HLD,
        S_DONE
    } state_t;

    state_t        state_q;
    logic          cmd_ready_q;
    logic          ld_cnt_q;
    logic          updn_cnt_q;
    logic          count_enb_q;
    logic          busy_q;
    logic          done_q;
    logic          sat_q;
    logic [DW-1:0] data_in_q;
    logic [DW-1:0] shadow_q;
    logic [DW-1:0] rem_q;
    logic [DW-1:0] shadow_d;

    // The counter steps at the same edge as the shadow, so the shadow follows updn_cnt.
    assign shadow_d = updn_cnt_q ? shadow_q + DW'(1) : shadow_q - DW'(1);

`ifdef CNT_CTRL_SAT_EN
    logic entry_bound;
    logic step_bound;
    assign entry_bound = cmd_op[0] ? (shadow_q == '0) : (shadow_q == '1);
    assign step_bound  = updn_cnt_q ? (shadow_d == '1) : (shadow_d == '0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            ld_cnt_q    <= 1'b1;
            updn_cnt_q  <= 1'b1;
            count_enb_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
            data_in_q   <= '0;
            shadow_q    <= '0;
            rem_q       <= '0;
        end else begin
            done_q <= 1'b0;
            sat_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rem_q       <= cmd_arg;
                        if (cmd_op == OP_LOAD) begin
                            state_q   <= S_LOAD;
                            ld_cnt_q  <= 1'b0;
                            data_in_q <= cmd_arg;
                        end else if (cmd_arg == '0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (cmd_op == OP_HOLD) begin
                            state_q <= S_HLD;
                        end
`ifdef CNT_CTRL_SAT_EN
                        else if (entry_bound) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            sat_q   <= 1'b1;
                        end
`endif
                        else begin
                            state_q     <= S_RUN;
                            count_enb_q <= 1'b1;
                            updn_cnt_q  <= ~cmd_op[0];
                        end
                    end
                end
                S_LOAD: begin
                    ld_cnt_q <= 1'b1;
                    shadow_q <= data_in_q;
                    state_q  <= S_DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                S_RUN: begin
                    shadow_q <= shadow_d;
                    rem_q    <= rem_q - DW'(1);
                    if (rem_q == DW'(1)) begin
                        count_enb_q <= 1'b0;
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
`ifdef CNT_CTRL_SAT_EN
                    else if (step_bound) begin
                        count_enb_q <= 1'b0;
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        sat_q       <= 1'b1;
                    end
`endif
                end
                S_HLD: begin
                    rem_q <= rem_q - DW'(1);
                    if (rem_q == DW'(1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign ld_cnt_    = ld_cnt_q;
    assign updn_cnt   = updn_cnt_q;
    assign count_enb  = count_enb_q;
    assign data_in    = data_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sat        = sat_q;
    assign shadow_cnt = shadow_q;
endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// tb/tb_counter_cmd_ctrl.sv - directed table, corner sequences and random commands vs a transaction model
module tb_counter_cmd_ctrl;
    localparam int DW = 8;
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    logic          clk = 1'b0;
    logic          rst_ = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [DW-1:0] cmd_arg = '0;
    logic          ld_cnt_;
    logic          updn_cnt;
    logic          count_enb;
    logic [DW-1:0] data_in;
    logic          busy;
    logic          done;
    logic          sat;
    logic [DW-1:0] shadow_cnt;

    always #5 clk = ~clk;

    counter_cmd_ctrl #(.DW(DW)) dut (
        .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt),
        .count_enb(count_enb), .data_in(data_in), .busy(busy), .done(done),
        .sat(sat), .shadow_cnt(shadow_cnt)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] arg;
        logic [7:0] exp_shadow;
        int         exp_enb;
        logic       exp_sat;
        int         exp_d;
    } vec_t;

    vec_t       tbl[15];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] model_shadow = 8'h00;

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Whole-command outcome from the command rules: cycles of activity, count cycles, final value.
    function automatic void model(input logic [1:0] op, input logic [7:0] arg, input logic [7:0] s,
                                  output logic [7:0] fin, output int enb, output logic sat_e,
                                  output int d);
        int k;
        sat_e = 1'b0;
        enb   = 0;
        fin   = s;
        d     = 0;
        case (op)
            OP_LOAD: begin fin = arg; d = 1; end
            OP_HOLD: begin d = int'(arg); end
            default: begin
                k = int'(arg);
`ifdef CNT_CTRL_SAT_EN
                begin
                    int room;
                    room = (op == OP_UP) ? 255 - int'(s) : int'(s);
                    if (k > room) begin k = room; sat_e = 1'b1; end
                end
`endif
                enb = k;
                d   = k;
                fin = (op == OP_UP) ? 8'(int'(s) + k) : 8'(int'(s) - k);
            end
        endcase
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg,
                           output int d, output int enb, output int ld, output int busy_n,
                           output int viol, output logic [7:0] fin, output logic sat_o,
                           output bit ok);
        int w;
        d = 0; enb = 0; ld = 0; busy_n = 0; viol = 0; fin = '0; sat_o = 1'b0; ok = 1'b0;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (count_enb) begin
                enb++;
                if (updn_cnt != !op[0]) viol++;
            end
            if (!ld_cnt_) begin
                ld++;
                if (data_in != arg) viol++;
                if (count_enb) viol++;
            end
            if (done) begin
                d = k; fin = shadow_cnt; sat_o = sat; ok = 1'b1;
                if (busy) viol++;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic apply(input string name, input logic [1:0] op, input logic [7:0] arg,
                         input logic [7:0] e_shadow, input int e_enb, input logic e_sat,
                         input int e_d);
        int d, enb, ld, busy_n, viol;
        logic [7:0] fin;
        logic sat_o;
        bit ok;
        run_cmd(op, arg, d, enb, ld, busy_n, viol, fin, sat_o, ok);
        if (ok) begin
            check({name, "_shadow"}, int'(fin), int'(e_shadow));
            check({name, "_enb_cycles"}, enb, e_enb);
            check({name, "_sat"}, int'(sat_o), int'(e_sat));
            check({name, "_done_lat"}, d, e_d);
            check({name, "_busy_cycles"}, busy_n, e_d);
            check({name, "_ld_cycles"}, ld, (op == OP_LOAD) ? 1 : 0);
            check({name, "_pin_viol"}, viol, 0);
        end
        model_shadow = e_shadow;
    endtask

    initial begin
        logic [7:0] e_fin, arg;
        logic [1:0] op;
        int e_enb, e_d, sel;
        logic e_sat;

        tbl[0]  = '{OP_LOAD, 8'hA5, 8'hA5, 0, 1'b0, 1};
        tbl[1]  = '{OP_LOAD, 8'hFD, 8'hFD, 0, 1'b0, 1};
`ifdef CNT_CTRL_SAT_EN
        tbl[2]  = '{OP_UP,   8'd5,  8'hFF, 2, 1'b1, 2};
`else
        tbl[2]  = '{OP_UP,   8'd5,  8'h02, 5, 1'b0, 5};
`endif
        tbl[3]  = '{OP_LOAD, 8'h10, 8'h10, 0, 1'b0, 1};
        tbl[4]  = '{OP_DOWN, 8'd3,  8'h0D, 3, 1'b0, 3};
        tbl[5]  = '{OP_HOLD, 8'd4,  8'h0D, 0, 1'b0, 4};
        tbl[6]  = '{OP_UP,   8'd0,  8'h0D, 0, 1'b0, 0};
        tbl[7]  = '{OP_LOAD, 8'hFE, 8'hFE, 0, 1'b0, 1};
        tbl[8]  = '{OP_UP,   8'd1,  8'hFF, 1, 1'b0, 1};
`ifdef CNT_CTRL_SAT_EN
        tbl[9]  = '{OP_UP,   8'd2,  8'hFF, 0, 1'b1, 0};
        tbl[10] = '{OP_LOAD, 8'h00, 8'h00, 0, 1'b0, 1};
        tbl[11] = '{OP_DOWN, 8'd1,  8'h00, 0, 1'b1, 0};
        tbl[12] = '{OP_LOAD, 8'h0D, 8'h0D, 0, 1'b0, 1};
        tbl[13] = '{OP_UP,   8'hFF, 8'hFF, 242, 1'b1, 242};
`else
        tbl[9]  = '{OP_UP,   8'd2,  8'h01, 2, 1'b0, 2};
        tbl[10] = '{OP_LOAD, 8'h00, 8'h00, 0, 1'b0, 1};
        tbl[11] = '{OP_DOWN, 8'd1,  8'hFF, 1, 1'b0, 1};
        tbl[12] = '{OP_LOAD, 8'h0D, 8'h0D, 0, 1'b0, 1};
        tbl[13] = '{OP_UP,   8'hFF, 8'h0C, 255, 1'b0, 255};
`endif
        tbl[14] = '{OP_HOLD, 8'd0,  tbl[13].exp_shadow, 0, 1'b0, 0};

        // Reset held with a pending command: nothing may be accepted.
        rst_ = 1'b0; cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_arg = 8'h77;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ld_cnt_", int'(ld_cnt_), 1);
        check("rst_count_enb", int'(count_enb), 0);
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_shadow", int'(shadow_cnt), 0);
        check("rst_busy_done", int'({busy, done, sat}), 0);
        check("rst_updn_data", int'({updn_cnt, data_in}), 256);
        rst_ = 1'b1;
        @(negedge clk);
        check("ready_after_release", int'(cmd_ready), 1);
        check("no_accept_at_release", int'({busy, ld_cnt_}), 1);
        cmd_valid = 1'b0;

        for (int i = 0; i < 15; i++)
            apply($sformatf("tbl%0d", i), tbl[i].op, tbl[i].arg, tbl[i].exp_shadow,
                  tbl[i].exp_enb, tbl[i].exp_sat, tbl[i].exp_d);

        // Reset in the 4th count cycle of UP 10 aborts with no done pulse.
        apply("mid_load", OP_LOAD, 8'h40, 8'h40, 0, 1'b0, 1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 8'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_enb_before", int'(count_enb), 1);
        check("mid_shadow_before", int'(shadow_cnt), 8'h43);
        rst_ = 1'b0;
        @(negedge clk);
        check("mid_enb_after", int'(count_enb), 0);
        check("mid_busy_after", int'(busy), 0);
        check("mid_shadow_after", int'(shadow_cnt), 0);
        check("mid_no_done", int'({done, sat}), 0);
        check("mid_ld_ready", int'({ld_cnt_, cmd_ready}), 2);
        rst_ = 1'b1;
        @(negedge clk);
        check("mid_ready_release", int'(cmd_ready), 1);
        check("mid_still_no_done", int'(done), 0);
        model_shadow = 8'h00;

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == OP_LOAD) begin
                sel = $urandom_range(0, 5);
                arg = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : (sel == 2) ? 8'hFE :
                      (sel == 3) ? 8'hFF : 8'($urandom);
            end else begin
                arg = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(200, 255))
                                                  : 8'($urandom_range(0, 12));
            end
            model(op, arg, model_shadow, e_fin, e_enb, e_sat, e_d);
            apply($sformatf("rnd%0d", i), op, arg, e_fin, e_enb, e_sat, e_d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
